// File: rtl/boreal_sram_dma.sv
// boreal_sram_dma: single-outstanding FILL / CHECK / COPY engine on the boreal SRAM tile port.
// Build option: define BOREAL_DMA_INCR_PATTERN_EN so FILL data / CHECK expectation step by one per word.
module boreal_sram_dma #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_pattern,
  output logic             req_valid,
  output logic             req_we,
  output logic [31:0]      req_addr,
  output logic [31:0]      req_wdata,
  output logic [3:0]       req_wstrb,
  input  logic             resp_valid,
  input  logic [31:0]      resp_rdata,
  input  logic             resp_err,
  output logic             done_valid,
  output logic [3:0]       done_status,
  output logic [LEN_W-1:0] done_mismatches,
  output logic [31:0]      done_fail_addr
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_CHECK = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP = 32'd4;
`ifdef BOREAL_DMA_INCR_PATTERN_EN
  localparam logic [31:0] PAT_STEP = 32'd1;
`else
  localparam logic [31:0] PAT_STEP = 32'd0;
`endif

  typedef enum logic [2:0] {IDLE, RD_ISSUE, WR_ISSUE, WAIT, DONE} state_t;

  state_t           state_r;
  logic [1:0]       op_r;
  logic [LEN_W-1:0] remaining_r;
  logic [LEN_W-1:0] mismatches_r;
  logic [31:0]      rd_ptr_r;
  logic [31:0]      wr_ptr_r;
  logic [31:0]      data_r;
  logic [31:0]      fail_addr_r;
  logic [3:0]       status_r;
  logic             wr_phase_r;
  logic [TW-1:0]    wait_cnt_r;

  logic [LEN_W-1:0] rem_dec_s;
  logic             word_mismatch_s;
  logic [3:0]       status_nx_s;
  logic [LEN_W-1:0] mism_nx_s;
  logic [31:0]      fail_nx_s;

  // Status/counter values after folding in the response currently on the port.
  always_comb begin
    rem_dec_s       = remaining_r - {{(LEN_W-1){1'b0}}, 1'b1};
    word_mismatch_s = (op_r == OP_CHECK) && (resp_rdata != data_r);
    status_nx_s     = status_r | {2'b00, word_mismatch_s, resp_err};
    if (word_mismatch_s) begin
      mism_nx_s = (&mismatches_r) ? mismatches_r : mismatches_r + {{(LEN_W-1){1'b0}}, 1'b1};
      fail_nx_s = status_r[1] ? fail_addr_r : rd_ptr_r;
    end else begin
      mism_nx_s = mismatches_r;
      fail_nx_s = fail_addr_r;
    end
  end

  // Command sequencer with registered request and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      op_r            <= 2'd0;
      remaining_r     <= {LEN_W{1'b0}};
      mismatches_r    <= {LEN_W{1'b0}};
      rd_ptr_r        <= 32'd0;
      wr_ptr_r        <= 32'd0;
      data_r          <= 32'd0;
      fail_addr_r     <= 32'd0;
      status_r        <= 4'd0;
      wr_phase_r      <= 1'b0;
      wait_cnt_r      <= {TW{1'b0}};
      cmd_ready       <= 1'b0;
      req_valid       <= 1'b0;
      req_we          <= 1'b0;
      req_addr        <= 32'd0;
      req_wdata       <= 32'd0;
      req_wstrb       <= 4'h0;
      done_valid      <= 1'b0;
      done_status     <= 4'd0;
      done_mismatches <= {LEN_W{1'b0}};
      done_fail_addr  <= 32'd0;
    end else begin
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_wstrb  <= 4'h0;
      done_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready       <= 1'b0;
            op_r            <= cmd_op;
            remaining_r     <= cmd_len;
            rd_ptr_r        <= cmd_src & ADDR_MASK;
            wr_ptr_r        <= cmd_dst & ADDR_MASK;
            data_r          <= cmd_pattern;
            status_r        <= 4'd0;
            mismatches_r    <= {LEN_W{1'b0}};
            fail_addr_r     <= 32'd0;
            done_status     <= 4'd0;
            done_mismatches <= {LEN_W{1'b0}};
            done_fail_addr  <= 32'd0;
            if (cmd_op == OP_RSVD) begin
              state_r     <= DONE;
              status_r    <= 4'b1000;
              done_status <= 4'b1000;
              done_valid  <= 1'b1;
            end else if (cmd_len == {LEN_W{1'b0}}) begin
              state_r    <= DONE;
              done_valid <= 1'b1;
            end else if (cmd_op == OP_FILL) begin
              state_r    <= WR_ISSUE;
              wr_phase_r <= 1'b1;
              req_valid  <= 1'b1;
              req_we     <= 1'b1;
              req_wstrb  <= 4'hF;
              req_addr   <= cmd_dst & ADDR_MASK;
              req_wdata  <= cmd_pattern;
            end else begin
              state_r    <= RD_ISSUE;
              wr_phase_r <= 1'b0;
              req_valid  <= 1'b1;
              req_addr   <= cmd_src & ADDR_MASK;
            end
          end
        end
        RD_ISSUE, WR_ISSUE: begin
          state_r    <= WAIT;
          wait_cnt_r <= {TW{1'b0}};
        end
        WAIT: begin
          if (resp_valid) begin
            status_r     <= status_nx_s;
            mismatches_r <= mism_nx_s;
            fail_addr_r  <= fail_nx_s;
            if ((op_r == OP_COPY) && !wr_phase_r) begin
              rd_ptr_r   <= rd_ptr_r + WORD_STEP;
              data_r     <= resp_rdata;
              state_r    <= WR_ISSUE;
              wr_phase_r <= 1'b1;
              req_valid  <= 1'b1;
              req_we     <= 1'b1;
              req_wstrb  <= 4'hF;
              req_addr   <= wr_ptr_r;
              req_wdata  <= resp_rdata;
            end else begin
              remaining_r <= rem_dec_s;
              case (op_r)
                OP_FILL: begin
                  wr_ptr_r <= wr_ptr_r + WORD_STEP;
                  data_r   <= data_r + PAT_STEP;
                end
                OP_CHECK: begin
                  rd_ptr_r <= rd_ptr_r + WORD_STEP;
                  data_r   <= data_r + PAT_STEP;
                end
                default: wr_ptr_r <= wr_ptr_r + WORD_STEP;
              endcase
              if (rem_dec_s == {LEN_W{1'b0}}) begin
                state_r         <= DONE;
                done_valid      <= 1'b1;
                done_status     <= status_nx_s;
                done_mismatches <= mism_nx_s;
                done_fail_addr  <= fail_nx_s;
              end else if (op_r == OP_FILL) begin
                state_r   <= WR_ISSUE;
                req_valid <= 1'b1;
                req_we    <= 1'b1;
                req_wstrb <= 4'hF;
                req_addr  <= wr_ptr_r + WORD_STEP;
                req_wdata <= data_r + PAT_STEP;
              end else begin
                // CHECK advances its read pointer now; COPY already advanced it in the read phase.
                state_r    <= RD_ISSUE;
                wr_phase_r <= 1'b0;
                req_valid  <= 1'b1;
                req_addr   <= (op_r == OP_CHECK) ? rd_ptr_r + WORD_STEP : rd_ptr_r;
              end
            end
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r         <= DONE;
            status_r        <= status_r | 4'b0100;
            done_valid      <= 1'b1;
            done_status     <= status_r | 4'b0100;
            done_mismatches <= mismatches_r;
            done_fail_addr  <= fail_addr_r;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
